// File: rtl/rom_line_cache_if.sv
// Signal bundle between the 68k program-ROM port, the ROM line cache and the
// SDRAM controller's ROM channel.
interface rom_line_cache_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              cache_req;
    logic [ADDR_W-1:0] cache_addr;
    logic              flush;
    logic              cache_valid;
    logic [DATA_W-1:0] cache_data;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rom_valid;

    // master is the surrounding system (requester plus SDRAM channel), slave is the cache
    modport master (
        output cache_req, cache_addr, flush, rom_data, rom_valid,
        input  cache_valid, cache_data, rom_req, rom_addr
    );
    modport slave (
        input  cache_req, cache_addr, flush, rom_data, rom_valid,
        output cache_valid, cache_data, rom_req, rom_addr
    );
endinterface

// File: rtl/rom_line_cache.sv
// Read-only direct-mapped cache with multi-word lines; a miss pulls the whole
// line from SDRAM as a fixed-length burst so sequential fetches then hit.
module rom_line_cache #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 7,
    parameter int LINE_W  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    rom_line_cache_if.slave bus
);
    localparam int TAG_W  = ADDR_W - INDEX_W - LINE_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int WORDS  = 1 << (INDEX_W + LINE_W);
    localparam int RA_W   = INDEX_W + LINE_W;
    localparam int BEAT_W = (LINE_W > 0) ? LINE_W : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((1 << LINE_W) - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RELEASE} state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   tag_lat_reg, tag_lat_next;
    logic [INDEX_W-1:0] idx_reg, idx_next;
    logic [BEAT_W-1:0]  off_reg, off_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;
    logic               flush_seen_reg, flush_seen_next;
    logic               cache_valid_reg, cache_valid_next;
    logic [DATA_W-1:0]  cache_data_reg, cache_data_next;
    logic               rom_req_reg, rom_req_next;
    logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
    logic [LINES-1:0]   valid_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [BEAT_W-1:0]  req_off;
    logic [RA_W-1:0]    ram_rd_addr, ram_wr_addr;
    logic               rd_en, ram_we, tag_we, install;

    logic [DATA_W-1:0]  data_mem [WORDS];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  ram_q_reg;
    logic [TAG_W-1:0]   tag_q_reg;

    assign req_tag = bus.cache_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = bus.cache_addr[LINE_W +: INDEX_W];

    // One-word lines have no offset field at all
    generate
        if (LINE_W > 0) begin : g_line
            assign req_off     = bus.cache_addr[BEAT_W-1:0];
            assign ram_rd_addr = {req_idx, req_off};
            assign ram_wr_addr = {idx_reg, beat_reg};
        end else begin : g_word
            assign req_off     = '0;
            assign ram_rd_addr = req_idx;
            assign ram_wr_addr = idx_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rd_en) ram_q_reg <= data_mem[ram_rd_addr];
        if (ram_we) data_mem[ram_wr_addr] <= bus.rom_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) tag_q_reg <= tag_mem[req_idx];
        if (tag_we) tag_mem[idx_reg] <= tag_lat_reg;
    end

    // Flush outranks a same-cycle install, so a line flushed on its last beat stays invalid
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    valid_reg[gi] <= 1'b0;
                else if (bus.flush)
                    valid_reg[gi] <= 1'b0;
                else if (install && (idx_reg == INDEX_W'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            tag_lat_reg     <= '0;
            idx_reg         <= '0;
            off_reg         <= '0;
            beat_reg        <= '0;
            flush_seen_reg  <= 1'b0;
            cache_valid_reg <= 1'b0;
            cache_data_reg  <= '0;
            rom_req_reg     <= 1'b0;
            rom_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            tag_lat_reg     <= tag_lat_next;
            idx_reg         <= idx_next;
            off_reg         <= off_next;
            beat_reg        <= beat_next;
            flush_seen_reg  <= flush_seen_next;
            cache_valid_reg <= cache_valid_next;
            cache_data_reg  <= cache_data_next;
            rom_req_reg     <= rom_req_next;
            rom_addr_reg    <= rom_addr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        tag_lat_next     = tag_lat_reg;
        idx_next         = idx_reg;
        off_next         = off_reg;
        beat_next        = beat_reg;
        flush_seen_next  = flush_seen_reg;
        cache_valid_next = 1'b0;
        cache_data_next  = cache_data_reg;
        rom_req_next     = rom_req_reg;
        rom_addr_next    = rom_addr_reg;
        rd_en            = 1'b0;
        ram_we           = 1'b0;
        tag_we           = 1'b0;
        install          = 1'b0;
        case (state_reg)
            IDLE: begin
                rd_en = 1'b1;
                if (bus.cache_req) begin
                    tag_lat_next = req_tag;
                    idx_next     = req_idx;
                    off_next     = req_off;
                    state_next   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (valid_reg[idx_reg] && (tag_q_reg == tag_lat_reg)) begin
                    cache_data_next  = ram_q_reg;
                    cache_valid_next = 1'b1;
                    state_next       = RELEASE;
                end else begin
                    rom_req_next    = 1'b1;
                    rom_addr_next   = ADDR_W'({tag_lat_reg, idx_reg}) << LINE_W;
                    beat_next       = '0;
                    flush_seen_next = 1'b0;
                    state_next      = FILL;
                end
            end
            FILL: begin
                if (bus.flush) flush_seen_next = 1'b1;
                if (bus.rom_valid) begin
                    ram_we    = 1'b1;
                    beat_next = beat_reg + BEAT_W'(1);
                    if (beat_reg == off_reg) cache_data_next = bus.rom_data;
                    if (beat_reg == LAST_BEAT) begin
                        tag_we       = 1'b1;
                        install      = !flush_seen_reg;
                        rom_req_next = 1'b0;
                        beat_next    = '0;
                        // A requester that let go mid-burst gets no data pulse
                        if (bus.cache_req) begin
                            cache_valid_next = 1'b1;
                            state_next       = RELEASE;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            RELEASE: begin
                if (!bus.cache_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cache_valid = cache_valid_reg;
    assign bus.cache_data  = cache_data_reg;
    assign bus.rom_req     = rom_req_reg;
    assign bus.rom_addr    = rom_addr_reg;
endmodule
